// File: rtl/i2c_cfg_seq.sv
// Codec configuration sequencer: walks a fixed register table and issues
// START / DEV / HI / LO / STOP requests to an I2C byte engine, with per-entry
// retry, a response timeout and sticky done/error status.
module i2c_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       go,
  output logic       i2c_start,
  output logic       i2c_write,
  output logic       i2c_stop,
  output logic [7:0] i2c_data,
  input  logic       i2c_cmd_ok,
  input  logic       i2c_cmd_err,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_index
);

  localparam int unsigned N_ENTRIES = 11;
  localparam int unsigned RETRY_W   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, START, DEV, HI, LO, STOP, NEXT, RSTOP, FIN
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           entry_q, entry_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [15:0]          tmo_q, tmo_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [3:0]           err_idx_q, err_idx_d;
  logic                 start_q, start_d;
  logic                 write_q, write_d;
  logic                 stop_q, stop_d;
  logic [7:0]           data_q, data_d;
  logic                 busy_q, busy_d;

  logic                 req_act;
  logic                 tmo_hit;
  logic                 rsp_err;
  logic                 rsp_ok;
  logic [15:0]          cur_entry;

  // Register table: {reg[6:0], val[8:0]}
  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_entry = {7'h0F, 9'h000};
      4'd1:    cfg_entry = {7'h00, 9'h017};
      4'd2:    cfg_entry = {7'h01, 9'h017};
      4'd3:    cfg_entry = {7'h02, 9'h079};
      4'd4:    cfg_entry = {7'h03, 9'h079};
      4'd5:    cfg_entry = {7'h04, 9'h012};
      4'd6:    cfg_entry = {7'h05, 9'h000};
      4'd7:    cfg_entry = {7'h06, 9'h000};
      4'd8:    cfg_entry = {7'h07, 9'h002};
      4'd9:    cfg_entry = {7'h08, 9'h000};
      4'd10:   cfg_entry = {7'h09, 9'h001};
      default: cfg_entry = 16'h0000;
    endcase
  endfunction

  // Response qualification: only while a request is up; error (or timeout) wins over ok
  always_comb begin
    req_act = (state_q == START) || (state_q == DEV) || (state_q == HI) ||
              (state_q == LO) || (state_q == STOP) || (state_q == RSTOP);
    tmo_hit = req_act && (tmo_q == (TIMEOUT - 16'd1));
    rsp_err = req_act && (i2c_cmd_err || tmo_hit);
    rsp_ok  = req_act && i2c_cmd_ok && !rsp_err;
  end

  // State and all registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      entry_q   <= 4'd0;
      retry_q   <= '0;
      tmo_q     <= 16'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= 4'd0;
      start_q   <= 1'b0;
      write_q   <= 1'b0;
      stop_q    <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      start_q   <= start_d;
      write_q   <= write_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, sequencing counters and sticky status
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = 4'd0;
          entry_d   = 4'd0;
          retry_d   = '0;
          state_d   = START;
        end
      end
      START: begin
        if (rsp_err)     state_d = RSTOP;
        else if (rsp_ok) state_d = DEV;
      end
      DEV: begin
        if (rsp_err)     state_d = RSTOP;
        else if (rsp_ok) state_d = HI;
      end
      HI: begin
        if (rsp_err)     state_d = RSTOP;
        else if (rsp_ok) state_d = LO;
      end
      LO: begin
        if (rsp_err)     state_d = RSTOP;
        else if (rsp_ok) state_d = STOP;
      end
      STOP: begin
        if (rsp_err)     state_d = RSTOP;
        else if (rsp_ok) state_d = NEXT;
      end
      NEXT: begin
        if (entry_q == 4'(N_ENTRIES - 1)) begin
          state_d = FIN;
        end else begin
          entry_d = entry_q + 4'd1;
          retry_d = '0;
          state_d = START;
        end
      end
      RSTOP: begin
        if (rsp_err || rsp_ok) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = START;
          end else begin
            error_d   = 1'b1;
            err_idx_d = entry_q;
            state_d   = IDLE;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timeout counter restarts on every state change, runs while a request is up
    if (state_d != state_q) tmo_d = 16'd0;
    else if (req_act)       tmo_d = tmo_q + 16'd1;
  end

  // Request outputs decoded from the upcoming state so they register with it
  always_comb begin
    start_d   = 1'b0;
    write_d   = 1'b0;
    stop_d    = 1'b0;
    data_d    = 8'h00;
    busy_d    = (state_d != IDLE);
    cur_entry = cfg_entry(entry_d);
    case (state_d)
      START: start_d = 1'b1;
      DEV: begin
        write_d = 1'b1;
        data_d  = DEV_ADDR;
      end
      HI: begin
        write_d = 1'b1;
        data_d  = cur_entry[15:8];
      end
      LO: begin
        write_d = 1'b1;
        data_d  = cur_entry[7:0];
      end
      STOP, RSTOP: stop_d = 1'b1;
      default: ;
    endcase
  end

  assign i2c_start = start_q;
  assign i2c_write = write_q;
  assign i2c_stop  = stop_q;
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_idx_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Scoreboard bench for i2c_cfg_seq: a byte-engine responder answers requests,
// expected requests/status are queued at go, a monitor pops and compares.
module tb_i2c_cfg_seq;

  localparam int TMO     = 20;
  localparam int K_NONE  = 0;
  localparam int K_START = 1;
  localparam int K_WRITE = 2;
  localparam int K_STOP  = 3;
  localparam int K_MULTI = 4;

  logic       sys_clk, sys_rst_n, go;
  logic       i2c_start, i2c_write, i2c_stop;
  logic [7:0] i2c_data;
  logic       i2c_cmd_ok, i2c_cmd_err;
  logic       busy, done, error;
  logic [3:0] err_index;

  i2c_cfg_seq #(.DEV_ADDR(8'h34), .TIMEOUT(16'(TMO)), .MAX_RETRY(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .go          (go),
    .i2c_start   (i2c_start),
    .i2c_write   (i2c_write),
    .i2c_stop    (i2c_stop),
    .i2c_data    (i2c_data),
    .i2c_cmd_ok  (i2c_cmd_ok),
    .i2c_cmd_err (i2c_cmd_err),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_index   (err_index)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct { int kind; int data; int hold; } req_t;
  typedef struct { int done; int error; int idx; } st_t;

  req_t exp_q[$];
  st_t  st_q[$];
  int   total = 0;
  int   bad   = 0;

  // Hand-computed HI/LO bytes per table entry
  int hi_tab [11] = '{32'h1E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08,
                      32'h0A, 32'h0C, 32'h0E, 32'h10, 32'h12};
  int lo_tab [11] = '{32'h00, 32'h17, 32'h17, 32'h79, 32'h79, 32'h12,
                      32'h00, 32'h00, 32'h02, 32'h00, 32'h01};

  // Responder fault mode, owned by the stimulus process
  int m_id = 0, m_ent = -1, m_pos = 0, m_once = 0, m_both = 0, m_nostart = 0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int cur_kind();
    int n;
    n = int'(i2c_start) + int'(i2c_write) + int'(i2c_stop);
    if (n == 0) return K_NONE;
    if (n > 1) return K_MULTI;
    if (i2c_start) return K_START;
    if (i2c_write) return K_WRITE;
    return K_STOP;
  endfunction

  function automatic void push_req(input int k, input int d, input int h);
    req_t r;
    r.kind = k; r.data = d; r.hold = h;
    exp_q.push_back(r);
  endfunction

  function automatic void push_entry(input int e);
    push_req(K_START, -1, 4);
    push_req(K_WRITE, 32'h34, 4);
    push_req(K_WRITE, hi_tab[e], 4);
    push_req(K_WRITE, lo_tab[e], 4);
    push_req(K_STOP, -1, 4);
  endfunction

  function automatic void push_st(input int d, input int e, input int idx);
    st_t s;
    s.done = d; s.error = e; s.idx = idx;
    st_q.push_back(s);
  endfunction

  function automatic void set_mode(input int ent, input int pos, input int once,
                                   input int both, input int nostart);
    m_ent = ent; m_pos = pos; m_once = once; m_both = both; m_nostart = nostart;
    m_id++;
  endfunction

  // Byte-engine responder: answers on the 4th cycle a request is seen
  int r_cnt, r_kind, r_data, r_prev, r_ent, r_wrn, r_rstop, r_injected, r_seen, r_pos, r_inj, r_k;
  initial begin
    i2c_cmd_ok = 1'b0; i2c_cmd_err = 1'b0;
    r_cnt = 0; r_kind = 0; r_data = 0; r_prev = 0; r_ent = 0; r_wrn = 0;
    r_rstop = 0; r_injected = 0; r_seen = 0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (r_seen != m_id) begin
        r_seen = m_id; r_ent = 0; r_wrn = 0; r_rstop = 0; r_injected = 0;
      end
      i2c_cmd_ok = 1'b0; i2c_cmd_err = 1'b0;
      r_k = cur_kind();
      if (r_k == K_NONE) begin
        r_cnt = 0; r_prev = 0;
      end else begin
        if (r_prev != 0 || r_k != r_kind || int'(i2c_data) != r_data) r_cnt = 0;
        r_kind = r_k; r_data = int'(i2c_data); r_prev = 0;
        if (r_cnt == 3 && !(r_k == K_START && m_nostart != 0)) begin
          r_cnt = 0; r_prev = 1;
          if (r_k == K_START) begin r_pos = 0; r_wrn = 0; end
          else if (r_k == K_WRITE) begin r_pos = r_wrn + 1; r_wrn++; end
          else r_pos = (r_rstop != 0) ? 5 : 4;
          r_inj = int'(m_ent == r_ent && m_pos == r_pos && !(m_once != 0 && r_injected != 0));
          if (r_inj != 0) begin
            r_injected = 1; i2c_cmd_err = 1'b1; i2c_cmd_ok = (m_both != 0);
          end else begin
            i2c_cmd_ok = 1'b1;
          end
          if (r_k == K_STOP && r_rstop != 0) r_rstop = 0;
          else if (r_k == K_STOP && r_inj == 0) r_ent++;
          if (r_inj != 0) r_rstop = 1;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  // Monitor: pops expected requests/status as the DUT presents them
  int p_kind = 0, p_data = 0, p_resp = 0, p_busy = 0;
  int c_valid = 0, c_len = 0, c_hold = 0, mk;
  int new_req;
  req_t er;
  st_t  es;
  initial begin
    forever begin
      @(negedge sys_clk);
      mk = cur_kind();
      if (!sys_rst_n) begin
        check("reset_outputs_zero",
              int'({i2c_start, i2c_write, i2c_stop, busy, done, error, err_index, i2c_data}), 0);
        p_kind = 0; p_data = 0; p_resp = 0; p_busy = 0; c_valid = 0;
        continue;
      end
      new_req = int'(mk != K_NONE && (p_kind == K_NONE || p_resp != 0 || mk != p_kind ||
                                       int'(i2c_data) != p_data));
      if (c_valid != 0 && (new_req != 0 || mk == K_NONE)) begin
        if (c_hold >= 0) check("req_hold_cycles", c_len, c_hold);
        c_valid = 0;
      end
      if (new_req != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", mk, K_NONE);
        end else begin
          er = exp_q.pop_front();
          check("req_kind", mk, er.kind);
          if (er.data >= 0) check("req_data", int'(i2c_data), er.data);
          c_valid = 1; c_len = 1; c_hold = er.hold;
        end
      end else if (mk != K_NONE) begin
        c_len++;
      end
      if (busy && p_busy == 0)
        check("status_cleared_on_go", int'({done, error, err_index}), 0);
      if (!busy && p_busy != 0) begin
        if (st_q.size() == 0) begin
          check("unexpected_seq_end", 1, 0);
        end else begin
          es = st_q.pop_front();
          check("end_done", int'(done), es.done);
          check("end_error", int'(error), es.error);
          check("end_err_index", int'(err_index), es.idx);
        end
      end
      p_kind = mk; p_data = int'(i2c_data);
      p_resp = int'(i2c_cmd_ok || i2c_cmd_err); p_busy = int'(busy);
    end
  end

  task automatic pulse_go(input int again_after);
    @(posedge sys_clk); #1 go = 1'b1;
    @(posedge sys_clk); #1 go = 1'b0;
    if (again_after > 0) begin
      repeat (again_after) @(posedge sys_clk);
      #1 go = 1'b1;
      @(posedge sys_clk); #1 go = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < budget) begin
      @(posedge sys_clk); n++;
    end
    check({name, "_pending_items"}, exp_q.size() + st_q.size(), 0);
    exp_q.delete(); st_q.delete();
    repeat (3) @(posedge sys_clk);
  endtask

  initial begin
    int n;
    go = 1'b0; sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Clean run through all entries
    set_mode(-1, 0, 0, 0, 0);
    for (int e = 0; e < 11; e++) push_entry(e);
    push_st(1, 0, 0);
    pulse_go(0);
    wait_drain("normal", 1500);

    // LO byte of entry 5 (0x08,0x12) fails once, entry is resent
    set_mode(5, 3, 1, 0, 0);
    for (int e = 0; e < 5; e++) push_entry(e);
    push_req(K_START, -1, 4); push_req(K_WRITE, 32'h34, 4);
    push_req(K_WRITE, 32'h08, 4); push_req(K_WRITE, 32'h12, 4); push_req(K_STOP, -1, 4);
    for (int e = 5; e < 11; e++) push_entry(e);
    push_st(1, 0, 0);
    pulse_go(0);
    wait_drain("lo_retry", 1500);

    // Every DEV byte of entry 2 fails: three attempts then abort
    set_mode(2, 1, 0, 0, 0);
    push_entry(0); push_entry(1);
    for (int a = 0; a < 3; a++) begin
      push_req(K_START, -1, 4); push_req(K_WRITE, 32'h34, 4); push_req(K_STOP, -1, 4);
    end
    push_st(0, 1, 2);
    pulse_go(0);
    wait_drain("dev_abort", 1500);

    // ok and err together on HI of entry 0: error wins
    set_mode(0, 2, 1, 1, 0);
    push_req(K_START, -1, 4); push_req(K_WRITE, 32'h34, 4);
    push_req(K_WRITE, 32'h1E, 4); push_req(K_STOP, -1, 4);
    for (int e = 0; e < 11; e++) push_entry(e);
    push_st(1, 0, 0);
    pulse_go(0);
    wait_drain("ok_err_both", 1500);

    // Second go while busy has no effect
    set_mode(-1, 0, 0, 0, 0);
    for (int e = 0; e < 11; e++) push_entry(e);
    push_st(1, 0, 0);
    pulse_go(50);
    wait_drain("go_while_busy", 1500);

    // START never answered: timeout after TMO cycles, three attempts
    set_mode(-1, 0, 0, 0, 1);
    for (int a = 0; a < 3; a++) begin
      push_req(K_START, -1, TMO); push_req(K_STOP, -1, 4);
    end
    push_st(0, 1, 0);
    pulse_go(0);
    wait_drain("start_timeout", 1500);

    // Reset during entry 6, then a fresh run from entry 0
    set_mode(-1, 0, 0, 0, 0);
    for (int e = 0; e < 6; e++) push_entry(e);
    push_req(K_START, -1, 4); push_req(K_WRITE, 32'h34, 4); push_req(K_WRITE, 32'h0A, 4);
    pulse_go(0);
    n = 0;
    while (!(r_ent == 6 && r_wrn == 1) && n < 1500) begin
      @(posedge sys_clk); n++;
    end
    check("reached_entry6_hi", int'(r_ent == 6 && r_wrn == 1), 1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    check("reset_mid_pending", exp_q.size(), 0);
    exp_q.delete(); st_q.delete();
    #1 sys_rst_n = 1'b1;
    set_mode(-1, 0, 0, 0, 0);
    for (int e = 0; e < 11; e++) push_entry(e);
    push_st(1, 0, 0);
    pulse_go(0);
    wait_drain("after_reset", 1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
